// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler.
// Collects the standard three-byte PS/2 mouse packet from a byte receiver. It
// turns the relative motion into an absolute cursor position clamped to
// 0..X_MAX / 0..Y_MAX and reports the button state.
//
// Ports:
//   CLOCK_50      in   sole clock, rising edge
//   reset         in   synchronous active-high reset
//   rx_data[7:0]  in   received byte, valid when rx_valid=1
//   rx_valid      in   one-cycle strobe per received byte
//   x_pos[9:0]    out  absolute cursor x, 0..X_MAX
//   y_pos[9:0]    out  absolute cursor y, 0..Y_MAX, 0 = top of screen
//   buttons[2:0]  out  {middle, right, left} from the last accepted packet
//   packet_valid  out  one-cycle pulse when new x_pos/y_pos/buttons appear
//   sync_error    out  one-cycle pulse on a discarded byte or inter-byte timeout
module ps2_mouse_packet #(
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_MAX          = 479,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] buttons,
  output logic       packet_valid,
  output logic       sync_error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  // That places the sync_error pulse TIMEOUT_CYCLES cycles after the last byte strobe.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 2);
  localparam logic signed [11:0] XMaxS = 12'(X_MAX);
  localparam logic signed [11:0] YMaxS = 12'(Y_MAX);

  typedef enum logic [1:0] {StWaitB0, StWaitB1, StWaitB2, StUpdate} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Only the b0 fields that are used later are kept: overflow, sign and button bits.
  logic            ovf_x_q, ovf_x_d, ovf_y_q, ovf_y_d;
  logic            sgn_x_q, sgn_x_d, sgn_y_q, sgn_y_d;
  logic [2:0]      btn_b0_q, btn_b0_d;
  logic [7:0]      b1_q, b1_d, b2_q, b2_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [2:0]      btn_q, btn_d;
  logic            pv_q, pv_d, se_q, se_d;

  logic signed [11:0] dx, dy, x_sum, y_sum;
  logic [9:0]         x_clamp, y_clamp;
  logic               is_filler;

  always_comb begin
    dx = ovf_x_q ? 12'sd0 : $signed({{4{sgn_x_q}}, b1_q});
    dy = ovf_y_q ? 12'sd0 : $signed({{4{sgn_y_q}}, b2_q});
    // Screen y grows downward while mouse dy is positive upward.
    x_sum = $signed({2'b00, x_q}) + dx;
    y_sum = $signed({2'b00, y_q}) - dy;

    if (x_sum < 12'sd0)      x_clamp = 10'd0;
    else if (x_sum > XMaxS)  x_clamp = XMaxS[9:0];
    else                     x_clamp = x_sum[9:0];

    if (y_sum < 12'sd0)      y_clamp = 10'd0;
    else if (y_sum > YMaxS)  y_clamp = YMaxS[9:0];
    else                     y_clamp = y_sum[9:0];
  end

  // ACK (0xFA) and self-test pass (0xAA) can show up between packets.
  assign is_filler = (rx_data == 8'hFA) || (rx_data == 8'hAA);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_x_d  = ovf_x_q;
    ovf_y_d  = ovf_y_q;
    sgn_x_d  = sgn_x_q;
    sgn_y_d  = sgn_y_q;
    btn_b0_d = btn_b0_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    x_d      = x_q;
    y_d      = y_q;
    btn_d    = btn_q;
    pv_d     = 1'b0;
    se_d     = 1'b0;

    unique case (state_q)
      StWaitB0, StUpdate: begin
        if (state_q == StUpdate) begin
          x_d     = x_clamp;
          y_d     = y_clamp;
          btn_d   = btn_b0_q;
          pv_d    = 1'b1;
          state_d = StWaitB0;
        end
        // A byte arriving during UPDATE is treated as a first byte, not dropped.
        if (rx_valid && !is_filler) begin
          if (!rx_data[3]) begin
            se_d = 1'b1;
          end else begin
            ovf_y_d  = rx_data[7];
            ovf_x_d  = rx_data[6];
            sgn_y_d  = rx_data[5];
            sgn_x_d  = rx_data[4];
            btn_b0_d = rx_data[2:0];
            cnt_d    = '0;
            state_d  = StWaitB1;
          end
        end
      end
      StWaitB1, StWaitB2: begin
        // A byte in the timeout cycle takes priority over the timeout.
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == StWaitB1) begin
            b1_d    = rx_data;
            state_d = StWaitB2;
          end else begin
            b2_d    = rx_data;
            state_d = StUpdate;
          end
        end else if (cnt_q == CntLast) begin
          se_d    = 1'b1;
          cnt_d   = '0;
          state_d = StWaitB0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StWaitB0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StWaitB0;
      cnt_q    <= '0;
      ovf_x_q  <= 1'b0;
      ovf_y_q  <= 1'b0;
      sgn_x_q  <= 1'b0;
      sgn_y_q  <= 1'b0;
      btn_b0_q <= 3'b000;
      b1_q     <= 8'h00;
      b2_q     <= 8'h00;
      x_q      <= 10'(X_MAX >> 1);
      y_q      <= 10'(Y_MAX >> 1);
      btn_q    <= 3'b000;
      pv_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_x_q  <= ovf_x_d;
      ovf_y_q  <= ovf_y_d;
      sgn_x_q  <= sgn_x_d;
      sgn_y_q  <= sgn_y_d;
      btn_b0_q <= btn_b0_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      x_q      <= x_d;
      y_q      <= y_d;
      btn_q    <= btn_d;
      pv_q     <= pv_d;
      se_q     <= se_d;
    end
  end

  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign buttons      = btn_q;
  assign packet_valid = pv_q;
  assign sync_error   = se_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet: a table of packets with hand-computed
// positions, plus hand-written sequences for filtering, timeout and reset cases.
module tb_ps2_mouse_packet;

  localparam int unsigned TC = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic       packet_valid, sync_error;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_mouse_packet #(
    .X_MAX          (639),
    .Y_MAX          (479),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .buttons      (buttons),
    .packet_valid (packet_valid),
    .sync_error   (sync_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         ex, ey;
    logic [2:0] eb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // Third byte: packet_valid must rise exactly two cycles after its strobe.
  task automatic send_tail(input string name, input logic [7:0] b2,
                           input int ex, input int ey, input logic [2:0] eb);
    rx_data  = b2;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    chk({name, " pv early"}, 32'(packet_valid), 0);
    @(negedge CLOCK_50);
    chk({name, " pv"}, 32'(packet_valid), 1);
    chk({name, " x"}, 32'(x_pos), 32'(ex));
    chk({name, " y"}, 32'(y_pos), 32'(ey));
    chk({name, " btn"}, 32'(buttons), 32'(eb));
    chk({name, " se"}, 32'(sync_error), 0);
    @(negedge CLOCK_50);
    chk({name, " pv late"}, 32'(packet_valid), 0);
  endtask

  task automatic send_packet(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int ex, input int ey,
                             input logic [2:0] eb);
    send_byte(b0);
    send_byte(b1);
    send_tail(name, b2, ex, ey, eb);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{b0: 8'h09, b1: 8'h05, b2: 8'h03, ex: 324, ey: 236, eb: 3'b001};
    vecs[1] = '{b0: 8'h0A, b1: 8'h10, b2: 8'hF0, ex: 340, ey: 0,   eb: 3'b010};
    vecs[2] = '{b0: 8'h2C, b1: 8'h00, b2: 8'h10, ex: 340, ey: 240, eb: 3'b100};
    vecs[3] = '{b0: 8'h18, b1: 8'hFF, b2: 8'h00, ex: 339, ey: 240, eb: 3'b000};
    vecs[4] = '{b0: 8'h88, b1: 8'h00, b2: 8'h20, ex: 339, ey: 240, eb: 3'b000};
    vecs[5] = '{b0: 8'h08, b1: 8'hFF, b2: 8'h00, ex: 594, ey: 240, eb: 3'b000};
    vecs[6] = '{b0: 8'h08, b1: 8'hFF, b2: 8'h00, ex: 639, ey: 240, eb: 3'b000};
    vecs[7] = '{b0: 8'h28, b1: 8'h00, b2: 8'h01, ex: 639, ey: 479, eb: 3'b000};

    @(negedge CLOCK_50);
    do_reset();
    chk("reset x", 32'(x_pos), 319);
    chk("reset y", 32'(y_pos), 239);
    chk("reset btn", 32'(buttons), 0);
    chk("reset pv", 32'(packet_valid), 0);
    chk("reset se", 32'(sync_error), 0);

    for (int i = 0; i < 8; i++) begin
      send_packet($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
                  vecs[i].ex, vecs[i].ey, vecs[i].eb);
    end

    // Large negative dx clamps to the left edge.
    do_reset();
    send_packet("neg1", 8'h18, 8'h00, 8'h00, 63, 239, 3'b000);
    send_packet("neg2", 8'h18, 8'h00, 8'h00, 0, 239, 3'b000);

    // X overflow forces dx to zero.
    do_reset();
    send_packet("xovf", 8'h48, 8'h7F, 8'h10, 319, 223, 3'b000);

    // Bad first byte flags an error; ACK is dropped silently.
    rx_data = 8'h01; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    chk("bad b0 se", 32'(sync_error), 1);
    chk("bad b0 pv", 32'(packet_valid), 0);
    @(negedge CLOCK_50);
    chk("bad b0 se off", 32'(sync_error), 0);
    rx_data = 8'hFA; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    chk("ack se", 32'(sync_error), 0);
    @(negedge CLOCK_50);
    chk("ack se2", 32'(sync_error), 0);
    chk("ack pv", 32'(packet_valid), 0);
    send_packet("after ack", 8'h08, 8'h01, 8'h00, 320, 223, 3'b000);

    // Silence after b0: sync_error exactly TC cycles after the strobe.
    rx_data = 8'h08; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    for (int k = 1; k <= int'(TC) + 1; k++) begin
      chk($sformatf("timeout se k=%0d", k), 32'(sync_error), (k == int'(TC)) ? 1 : 0);
      chk($sformatf("timeout pv k=%0d", k), 32'(packet_valid), 0);
      @(negedge CLOCK_50);
    end
    rx_data = 8'h00; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    chk("post-timeout se", 32'(sync_error), 1);
    @(negedge CLOCK_50);
    chk("post-timeout pv", 32'(packet_valid), 0);
    chk("post-timeout x", 32'(x_pos), 320);

    // b1 arrives in the very cycle the timeout would fire: the byte wins.
    rx_data = 8'h08; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    repeat (TC - 2) @(negedge CLOCK_50);
    rx_data = 8'h03; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    chk("edge se", 32'(sync_error), 0);
    @(negedge CLOCK_50);
    chk("edge se2", 32'(sync_error), 0);
    send_tail("edge", 8'h00, 323, 223, 3'b000);

    // Back-to-back packets: next b0 arrives during the UPDATE cycle.
    do_reset();
    rx_valid = 1'b1;
    rx_data = 8'h09; @(negedge CLOCK_50);
    rx_data = 8'h05; @(negedge CLOCK_50);
    rx_data = 8'h03; @(negedge CLOCK_50);
    rx_data = 8'h08;
    chk("b2b pv0", 32'(packet_valid), 0);
    @(negedge CLOCK_50);
    rx_data = 8'h01;
    chk("b2b pv1", 32'(packet_valid), 1);
    chk("b2b x1", 32'(x_pos), 324);
    chk("b2b y1", 32'(y_pos), 236);
    chk("b2b btn1", 32'(buttons), 1);
    @(negedge CLOCK_50);
    rx_data = 8'h00;
    chk("b2b pv2", 32'(packet_valid), 0);
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    chk("b2b pv3", 32'(packet_valid), 0);
    @(negedge CLOCK_50);
    chk("b2b pv4", 32'(packet_valid), 1);
    chk("b2b x2", 32'(x_pos), 325);
    chk("b2b y2", 32'(y_pos), 236);
    chk("b2b btn2", 32'(buttons), 0);
    @(negedge CLOCK_50);

    // Reset during UPDATE suppresses the pending packet.
    do_reset();
    send_byte(8'h08);
    send_byte(8'h01);
    rx_data = 8'h00; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("rst upd pv", 32'(packet_valid), 0);
    chk("rst upd x", 32'(x_pos), 319);
    @(negedge CLOCK_50);
    chk("rst upd pv2", 32'(packet_valid), 0);

    // Reset between b1 and b2 drops the stale bytes.
    send_byte(8'h09);
    send_byte(8'h05);
    do_reset();
    send_packet("rst mid", 8'h09, 8'h05, 8'h03, 324, 236, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet.md
PS2_MOUSE_PACKET -- requirements
Module: ps2_mouse_packet

Interface
REQ-001 Parameter X_MAX, default 639: largest legal x_pos value.
REQ-002 Parameter Y_MAX, default 479: largest legal y_pos value.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: maximum CLOCK_50 cycles allowed between bytes of one packet (2 ms); legal range 2..2^20.
REQ-004 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx_data  in  8  byte from the PS/2 receiver; valid only when rx_valid=1.
REQ-007 rx_valid  in  1  one-cycle strobe per received byte (the receiver's received_data_en).
REQ-008 x_pos  out  10  absolute cursor x, unsigned, 0..X_MAX.
REQ-009 y_pos  out  10  absolute cursor y, unsigned, 0..Y_MAX, 0 = top of screen.
REQ-010 buttons  out  3  {middle, right, left} from the last accepted packet.
REQ-011 packet_valid  out  1  one-cycle pulse; new x_pos, y_pos and buttons are first visible in this cycle.
REQ-012 sync_error  out  1  one-cycle pulse on a discarded byte or an inter-byte timeout.

Function
REQ-013 FSM states: WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
REQ-014 WAIT_B0, rx_valid with rx_data = 0xFA or 0xAA: discard the byte silently and stay in WAIT_B0 (ACK / self-test filtering).
REQ-015 WAIT_B0, rx_valid with rx_data[3]=0: discard the byte, pulse sync_error in the next cycle, and stay in WAIT_B0.
REQ-016 WAIT_B0, rx_valid with any other byte: latch it as b0 and go to WAIT_B1.
REQ-017 WAIT_B1, rx_valid: latch b1 and go to WAIT_B2; WAIT_B2, rx_valid: latch b2 and go to UPDATE.
REQ-018 UPDATE lasts exactly one cycle and then returns to WAIT_B0.
REQ-019 An rx_valid that arrives while in UPDATE is evaluated exactly as in WAIT_B0 (REQ-014..016); the byte is not lost.
REQ-020 dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], b2}.
REQ-021 b0[6]=1 (X overflow) forces dx=0; b0[7]=1 (Y overflow) forces dy=0.
REQ-022 In UPDATE, x_next = x_pos + dx and y_next = y_pos - dy, both computed signed at 12 bits minimum.
REQ-023 Clamp each result to the range 0..MAX before registering it.
REQ-024 In UPDATE, buttons <= {b0[2], b1'... } is defined as buttons <= {b0[2], b0[1], b0[0]}.
REQ-025 Outputs are registered; packet_valid is high exactly 2 cycles after the rx_valid cycle of b2, for one cycle.
REQ-026 The timeout counter clears on every accepted byte and counts only in WAIT_B1 and WAIT_B2.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: pulse sync_error, drop the partial packet, go to WAIT_B0, and leave the outputs unchanged.
REQ-028 rx_valid in the same cycle as the timeout: the byte wins; it is accepted and no timeout occurs.
REQ-029 x_pos, y_pos and buttons change only in UPDATE; between packets they hold their values.

Reset
REQ-030 On reset: state WAIT_B0, timeout counter 0, x_pos = X_MAX>>1 (319), y_pos = Y_MAX>>1 (239), buttons 000, packet_valid 0, sync_error 0.
REQ-031 Reset in any state, including mid-packet or in UPDATE, discards partial bytes and suppresses any pending packet_valid.

Verification
REQ-032 Reset; bytes 0x09,0x05,0x03 -> one packet_valid 2 cycles after the third strobe; buttons=001, x_pos=324, y_pos=236.
REQ-033 Reset; 0x18,0x00,0x00 sent twice -> x_pos 63 after the first packet, then 0 (clamped); y_pos 239 throughout.
REQ-034 Reset; 0x48,0x7F,0x10 -> x_pos 319 (X overflow ignored), y_pos 223.
REQ-035 Bytes 0x01 then 0xFA -> sync_error pulses once for 0x01, no pulse for 0xFA, no packet_valid; a following 0x08,0x01,0x00 gives x_pos+1.
REQ-036 0x08 followed by silence -> sync_error exactly TIMEOUT_CYCLES cycles later; a following 0x00 produces a sync_error (it is treated as b0), not a packet.
REQ-037 Reset asserted between b1 and b2, then 0x09,0x05,0x03 -> positions equal the REQ-032 values; the stale packet has no effect.
